// File: rtl/data_types.sv
// rtl/data_types.sv - shared datapath word and instruction-queue entry types
package data_types;

    typedef logic [31:0] word32_t;

    typedef struct packed {
        word32_t instr;
        logic    spec;
    } iq_entry_t;

endpackage

// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - instruction queue constants and small helpers
package instr_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;

    // Decode of the branch-resolution inputs into the two outcomes the queue cares about.
    function automatic logic is_mispredict(input logic cond_eval, input logic corr_pred);
        return cond_eval & ~corr_pred;
    endfunction

    function automatic logic is_correct(input logic cond_eval, input logic corr_pred);
        return cond_eval & corr_pred;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch/resolve/dispatch signal bundle for the instruction queue
interface instr_queue_if;

    logic                 iq_write_i;
    data_types::word32_t  fetched_instr_i;
    logic                 issuing_branch_i;
    logic                 iq_full_o;
    logic                 cond_eval_i;
    logic                 corr_pred_i;
    logic                 dispatch_ready_i;
    logic                 instr_valid_o;
    data_types::word32_t  instr_o;
    logic                 instr_spec_o;

    modport master (
        output iq_write_i, fetched_instr_i, issuing_branch_i,
        output cond_eval_i, corr_pred_i, dispatch_ready_i,
        input  iq_full_o, instr_valid_o, instr_o, instr_spec_o
    );

    modport slave (
        input  iq_write_i, fetched_instr_i, issuing_branch_i,
        input  cond_eval_i, corr_pred_i, dispatch_ready_i,
        output iq_full_o, instr_valid_o, instr_o, instr_spec_o
    );

endinterface

// File: rtl/iq_ptr_ctrl.sv
// rtl/iq_ptr_ctrl.sv - read/write pointers and occupancy for the instruction queue
module iq_ptr_ctrl #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [PTR_W:0]   flush_amt,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W:0]   count,
    output logic             full
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush rewinds the tail over the squashed entries; the head is untouched.
            wr_ptr <= wr_ptr - flush_amt[PTR_W-1:0];
            count  <= count - flush_amt;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    assign full = (count == DEPTH_C);

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-dispatch instruction FIFO with speculative-entry squash/commit
module instr_queue
    import data_types::*;
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic          clk_i,
    input  logic          reset_i,
    instr_queue_if.slave  iq
);

    localparam int PTR_W = $clog2(DEPTH);

    word32_t            instr_mem [DEPTH];
    logic [DEPTH-1:0]   spec_q;
    logic               spec_active;
    logic [PTR_W:0]     spec_cnt;

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               valid;

    logic               mispredict;
    logic               correct;
    logic               push;
    logic               pop;
    logic               push_spec;
    logic               pop_spec;
    iq_entry_t          head;

    assign mispredict = is_mispredict(iq.cond_eval_i, iq.corr_pred_i);
    assign correct    = is_correct(iq.cond_eval_i, iq.corr_pred_i);
    assign valid      = (count != '0);
    assign push       = iq.iq_write_i & ~full & ~mispredict;
    assign pop        = valid & iq.dispatch_ready_i & ~mispredict;

    // A correct resolve commits everything, including what is written in the same cycle.
    assign push_spec  = push & spec_active & ~correct;
    assign pop_spec   = pop & spec_q[rd_ptr];

    iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push      (push),
        .pop       (pop),
        .flush     (mispredict),
        .flush_amt (spec_cnt),
        .rd_ptr    (rd_ptr),
        .wr_ptr    (wr_ptr),
        .count     (count),
        .full      (full)
    );

    always_ff @(posedge clk_i) begin
        if (push) instr_mem[wr_ptr] <= iq.fetched_instr_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            spec_q      <= '0;
            spec_cnt    <= '0;
            spec_active <= 1'b0;
        end else if (mispredict) begin
            spec_q      <= '0;
            spec_cnt    <= '0;
            spec_active <= 1'b0;
        end else if (correct) begin
            spec_q      <= '0;
            spec_cnt    <= '0;
            spec_active <= push & iq.issuing_branch_i;
        end else begin
            if (push) begin
                spec_q[wr_ptr] <= spec_active;
                if (iq.issuing_branch_i) spec_active <= 1'b1;
            end
            spec_cnt <= spec_cnt + (PTR_W+1)'(push_spec) - (PTR_W+1)'(pop_spec);
        end
    end

    assign head = '{instr: instr_mem[rd_ptr], spec: spec_q[rd_ptr]};

    assign iq.iq_full_o     = full;
    assign iq.instr_valid_o = valid;
    assign iq.instr_o       = head.instr;
    assign iq.instr_spec_o  = valid & head.spec;

    // Queued entries must read non-speculative from the head, then speculative up to the tail.
    logic contig_ok;
    always_comb begin
        contig_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count) begin
                if (spec_q[rd_ptr + PTR_W'(i)] != ((PTR_W+1)'(i) >= (count - spec_cnt)))
                    contig_ok = 1'b0;
            end
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        count <= (PTR_W+1)'(DEPTH));
    a_spec_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        spec_cnt <= count);
    a_spec_contig: assert property (@(posedge clk_i) disable iff (!reset_i)
        contig_ok);
    a_resolve_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        iq.cond_eval_i |-> spec_active);

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed self-checking bench for instr_queue
module tb_instr_queue;
    import data_types::*;

    localparam int DEPTH = 8;
    localparam word32_t BR0 = 32'h00C0_0063;
    localparam word32_t BR1 = 32'h00D0_0063;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_queue_if iq();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .iq      (iq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq.iq_write_i       = 1'b0;
        iq.fetched_instr_i  = '0;
        iq.issuing_branch_i = 1'b0;
        iq.cond_eval_i      = 1'b0;
        iq.corr_pred_i      = 1'b0;
        iq.dispatch_ready_i = 1'b0;
    endtask

    task automatic push(input word32_t d, input logic br);
        iq.iq_write_i       = 1'b1;
        iq.fetched_instr_i  = d;
        iq.issuing_branch_i = br;
        cyc();
        iq.iq_write_i       = 1'b0;
        iq.issuing_branch_i = 1'b0;
    endtask

    task automatic check_head(input string tag, input word32_t d, input logic sp);
        check({tag, ".valid"}, 32'(iq.instr_valid_o), 32'd1);
        check({tag, ".instr"}, iq.instr_o, d);
        check({tag, ".spec"},  32'(iq.instr_spec_o), 32'(sp));
    endtask

    task automatic pop_chk(input string tag, input word32_t d, input logic sp);
        check_head(tag, d, sp);
        iq.dispatch_ready_i = 1'b1;
        cyc();
        iq.dispatch_ready_i = 1'b0;
    endtask

    task automatic push_pop(input string tag, input word32_t d, input logic br,
                            input word32_t exp_d, input logic exp_sp);
        check_head(tag, exp_d, exp_sp);
        iq.iq_write_i       = 1'b1;
        iq.fetched_instr_i  = d;
        iq.issuing_branch_i = br;
        iq.dispatch_ready_i = 1'b1;
        cyc();
        iq.iq_write_i       = 1'b0;
        iq.issuing_branch_i = 1'b0;
        iq.dispatch_ready_i = 1'b0;
    endtask

    task automatic resolve(input logic corr);
        iq.cond_eval_i = 1'b1;
        iq.corr_pred_i = corr;
        cyc();
        iq.cond_eval_i = 1'b0;
        iq.corr_pred_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.full",  32'(iq.iq_full_o),     32'd0);
        check("rst.valid", 32'(iq.instr_valid_o), 32'd0);
        check("rst.spec",  32'(iq.instr_spec_o),  32'd0);
        rst_n = 1'b1;
        cyc();

        // single write becomes visible one cycle later
        push(32'h0000_0013, 1'b0);
        pop_chk("t1", 32'h0000_0013, 1'b0);
        check("t1.empty", 32'(iq.instr_valid_o), 32'd0);

        // fill, overflow drop, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("t2.notfull", 32'(iq.iq_full_o), 32'd0);
            push(32'h100 + 32'(i), 1'b0);
        end
        check("t2.full", 32'(iq.iq_full_o), 32'd1);
        push(32'hDEAD_BEEF, 1'b0);
        check("t2.drop.count", 32'(dut.count), 32'd8);
        for (int i = 0; i < DEPTH; i++) pop_chk("t2.pop", 32'h100 + 32'(i), 1'b0);
        check("t2.empty", 32'(iq.instr_valid_o), 32'd0);

        // mispredict squashes the three speculative entries (rd_ptr=1 here)
        push(BR0, 1'b1);
        for (int i = 0; i < 3; i++) push(32'h201 + 32'(i), 1'b0);
        check("t3.count",    32'(dut.count),       32'd4);
        check("t3.spec_cnt", 32'(dut.spec_cnt),    32'd3);
        check("t3.active",   32'(dut.spec_active), 32'd1);
        resolve(1'b0);
        check("t3.mp.count",  32'(dut.count),       32'd1);
        check("t3.mp.scnt",   32'(dut.spec_cnt),    32'd0);
        check("t3.mp.active", 32'(dut.spec_active), 32'd0);
        check("t3.mp.wr_ptr", 32'(dut.wr_ptr),      32'd2);
        push(32'h300, 1'b0);
        pop_chk("t3.br", BR0, 1'b0);
        pop_chk("t3.next", 32'h300, 1'b0);
        check("t3.empty", 32'(iq.instr_valid_o), 32'd0);

        // correct prediction commits the speculative entries
        push(BR0, 1'b1);
        for (int i = 0; i < 3; i++) push(32'h401 + 32'(i), 1'b0);
        check("t4.spec_cnt", 32'(dut.spec_cnt), 32'd3);
        resolve(1'b1);
        check("t4.count",    32'(dut.count),       32'd4);
        check("t4.scnt",     32'(dut.spec_cnt),    32'd0);
        check("t4.active",   32'(dut.spec_active), 32'd0);
        pop_chk("t4.br", BR0, 1'b0);
        for (int i = 0; i < 3; i++) pop_chk("t4.pop", 32'h401 + 32'(i), 1'b0);

        // correct resolve coinciding with a new branch push keeps speculation open
        push(BR0, 1'b1);
        push(32'h501, 1'b0);
        iq.iq_write_i       = 1'b1;
        iq.fetched_instr_i  = BR1;
        iq.issuing_branch_i = 1'b1;
        iq.cond_eval_i      = 1'b1;
        iq.corr_pred_i      = 1'b1;
        cyc();
        idle();
        check("t5.active", 32'(dut.spec_active), 32'd1);
        check("t5.scnt",   32'(dut.spec_cnt),    32'd0);
        check("t5.count",  32'(dut.count),       32'd3);
        push(32'h502, 1'b0);
        check("t5.scnt1", 32'(dut.spec_cnt), 32'd1);
        pop_chk("t5.br0", BR0, 1'b0);
        pop_chk("t5.e1",  32'h501, 1'b0);
        pop_chk("t5.br1", BR1, 1'b0);
        pop_chk("t5.e2",  32'h502, 1'b1);
        check("t5.scnt0", 32'(dut.spec_cnt), 32'd0);
        resolve(1'b1);
        check("t5.closed", 32'(dut.spec_active), 32'd0);

        // wrap: branch at slot 5, speculative at 6,7,0, mispredict rewinds wr_ptr 1 -> 6
        push(32'h600, 1'b0);
        push(32'h601, 1'b0);
        check("t6.wr5", 32'(dut.wr_ptr), 32'd5);
        push_pop("t6.a0", BR0, 1'b1, 32'h600, 1'b0);
        push_pop("t6.a1", 32'h6A0, 1'b0, 32'h601, 1'b0);
        push(32'h6A1, 1'b0);
        push(32'h6A2, 1'b0);
        check("t6.wr1",   32'(dut.wr_ptr),   32'd1);
        check("t6.scnt3", 32'(dut.spec_cnt), 32'd3);
        check("t6.cnt4",  32'(dut.count),    32'd4);
        resolve(1'b0);
        check("t6.wr6",  32'(dut.wr_ptr), 32'd6);
        check("t6.cnt1", 32'(dut.count),  32'd1);
        for (int k = 0; k < 12; k++)
            push_pop("t6.pp", 32'h700 + 32'(k), 1'b0,
                     (k == 0) ? BR0 : 32'h700 + 32'(k - 1), 1'b0);
        pop_chk("t6.last", 32'h70B, 1'b0);
        check("t6.empty", 32'(iq.instr_valid_o), 32'd0);
        check("t6.wr2",   32'(dut.wr_ptr), 32'd2);
        check("t6.rd2",   32'(dut.rd_ptr), 32'd2);

        // asynchronous reset while full
        for (int i = 0; i < DEPTH; i++) push(32'h800 + 32'(i), 1'b0);
        check("t7.full", 32'(iq.iq_full_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7.rst.valid", 32'(iq.instr_valid_o), 32'd0);
        check("t7.rst.full",  32'(iq.iq_full_o),     32'd0);
        check("t7.rst.count", 32'(dut.count),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("t7.post.valid", 32'(iq.instr_valid_o), 32'd0);
        push(32'h900, 1'b0);
        pop_chk("t7.after", 32'h900, 1'b0);
        check("t7.rd1", 32'(dut.rd_ptr), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Circular FIFO between the instruction fetch unit and the dispatch stage.
- Accepts fetched instructions from the fetch unit and back-pressures it with a full flag.
- Tags every entry written behind an unresolved branch as speculative.
- On a branch misprediction, squashes the speculative entries still queued. On a correct prediction, commits them.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- iq_write_i  input  1  fetch unit writes fetched_instr_i this cycle.
- fetched_instr_i  input  32 (word32_t)  instruction to enqueue.
- issuing_branch_i  input  1  the instruction being written is a conditional branch.
- iq_full_o  output  1  queue holds DEPTH entries.
- cond_eval_i  input  1  branch ALU resolved the outstanding branch this cycle.
- corr_pred_i  input  1  resolved branch was predicted correctly; qualified by cond_eval_i.
- dispatch_ready_i  input  1  dispatch accepts the head entry this cycle.
- instr_valid_o  output  1  head entry is valid.
- instr_o  output  32 (word32_t)  head instruction.
- instr_spec_o  output  1  head entry is speculative.

Behaviour:
- Reset (reset_i=0, asynchronous assert, synchronous release):
  - rd_ptr=0, wr_ptr=0, count=0, spec_active=0, spec_cnt=0, all spec bits=0.
  - Outputs: iq_full_o=0, instr_valid_o=0, instr_spec_o=0. instr_o is don't-care.
  - Reset mid-operation discards all contents.
- Storage: array of DEPTH words plus one spec bit per entry. Pointers wrap modulo DEPTH. count is PTR_W+1 bits.
- iq_full_o = (count==DEPTH), from registered count. instr_valid_o = (count!=0).
- instr_o and instr_spec_o read combinationally at rd_ptr.
- Write-to-visible latency: 1 cycle.
- Push = iq_write_i & ~iq_full_o & ~mispredict, where mispredict = cond_eval_i & ~corr_pred_i.
  - A write while full is dropped; the fetch unit never writes when full.
  - A write during a mispredict cycle is dropped.
- Pop = instr_valid_o & dispatch_ready_i & ~mispredict.
  - Dispatch is stalled for the mispredict cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - A pop when full frees the slot only for the next cycle, because full is registered.
- Speculation state: spec_active (1 bit) and spec_cnt (number of queued speculative entries, PTR_W+1 bits).
  - A pushed entry's spec bit = spec_active.
  - A branch entry itself is non-speculative. At most one unresolved branch exists, because fetch stalls branches while speculating.
  - Pushing with issuing_branch_i=1 sets spec_active next cycle.
  - Speculative push increments spec_cnt. Pop of a speculative head decrements it.
- Correct resolve (cond_eval_i & corr_pred_i):
  - Clear all spec bits and spec_cnt.
  - spec_active <= push & issuing_branch_i, so a new branch enqueued in the same cycle keeps speculation open.
  - A non-branch push in this cycle is written as non-speculative.
- Mispredict:
  - wr_ptr <= wr_ptr - spec_cnt; count <= count - spec_cnt.
  - spec_cnt=0, spec_active=0, all spec bits cleared.
  - Speculative entries already dispatched are killed downstream, outside this block.
- cond_eval_i with spec_active=0 is illegal. Covered by an assertion; no state change is required.
- Assertions:
  - count never exceeds DEPTH.
  - spec_cnt never exceeds count.
  - Speculative entries are always contiguous at the tail.

Decomposition:
- data_types package:
  - word32_t, reused.
  - New typedef iq_entry_t {word32_t instr; logic spec;}.
- Local package constant IQ_DEPTH_DEFAULT=8.
- One natural sub-module: iq_ptr_ctrl.
  - Inputs: push, pop, flush amount.
  - Outputs: rd_ptr, wr_ptr, count, full.
  - instr_queue keeps the storage array and speculation bookkeeping.

Test Plan:
1. Reset, then write 0x00000013 with dispatch_ready_i=0 → instr_valid_o=1 next cycle, instr_o=0x00000013, instr_spec_o=0.
2. 8 writes with no reads → iq_full_o=1 after the 8th. 9th write dropped. Then 8 pops return the entries in order. After the last pop, instr_valid_o=0.
3. Write branch 0x00C00063 (issuing_branch_i=1), then 3 non-branch writes → count=4, spec_cnt=3. Mispredict pulse → next cycle count=1, head=branch, wr_ptr=rd_ptr+1. Next write lands directly behind the branch.
4. Same as 3 but corr_pred_i=1 → count=4, all instr_spec_o=0 on dispatch, spec_active=0.
5. Correct resolve in the same cycle as a new branch push → new branch non-speculative, spec_active=1. A following write has instr_spec_o=1.
6. Pointer wrap: 20 interleaved push/pop cycles with a mispredict while wr_ptr=1, spec_cnt=3 → wr_ptr rolls back to DEPTH-2 and FIFO order is preserved. Separately, asserting reset_i=0 mid-stream clears instr_valid_o and iq_full_o immediately, without waiting for a clock edge.
